// File: rtl/mux_nx1_rr.sv
// N-to-1 registered multiplexer with per-channel valid/ready and a one-word output register.
// Optional feature macro MUX_RR_EN: adds a round-robin arbiter selected by mode; without it, sel always applies.
module mux_nx1_rr #(
    parameter int N  = 8,
    parameter int W  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [SW-1:0]  sel,
    input  logic           mode,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic          out_valid_q, out_valid_d;

    logic          load;
    logic          xfer;
    logic          use_rr;
    logic          rr_vld;
    logic [SW-1:0] rr_grant;
    logic          grant_vld;
    logic [SW-1:0] grant;
    logic [W-1:0]  ch_data [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ch_data[i] = in_data[i*W +: W];
        end
    end

    // Reset gates load so no input handshake can complete while rst is high.
    assign load = !rst && (!out_valid_q || out_ready);

`ifdef MUX_RR_EN
    logic [SW-1:0] ptr_q, ptr_d;

    assign use_rr = mode;

    always_comb begin : rr_scan
        int idx;
        rr_vld   = 1'b0;
        rr_grant = '0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!rr_vld && in_valid[SW'(idx)]) begin
                rr_vld   = 1'b1;
                rr_grant = SW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer && use_rr) begin
            ptr_d = (grant == SW'(N-1)) ? '0 : grant + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic mode_unused;

    assign mode_unused = mode;
    assign use_rr      = 1'b0;
    assign rr_vld      = 1'b0;
    assign rr_grant    = '0;
`endif

    always_comb begin
        if (use_rr) begin
            grant     = rr_grant;
            grant_vld = rr_vld;
        end else begin
            grant     = sel;
            grant_vld = (32'(sel) < N);
        end
    end

    always_comb begin
        in_ready = '0;
        if (load && grant_vld) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign xfer = |(in_valid & in_ready);

    // A drained output register keeps its last word and channel.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (xfer) begin
            out_data_d  = ch_data[grant];
            out_ch_d    = grant;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Self-checking bench for mux_nx1_rr: reference model plus scoreboard queue of expected output words.
`timescale 1ns/1ps
module tb_mux_nx1_rr;
    localparam int N  = 8;
    localparam int W  = 4;
    localparam int SW = 3;
`ifdef MUX_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic [SW-1:0]  sel = '0;
    logic           mode = 1'b0;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;
    logic           out_valid;
    logic           out_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [SW+W-1:0] sb[$];
    logic            m_valid = 1'b0;
    int              m_ptr = 0;
    logic [W-1:0]    m_last_data = '0;
    logic [SW-1:0]   m_last_ch = '0;

    mux_nx1_rr #(.N(N), .W(W), .SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] ramp(input logic [W-1:0] base);
        logic [N*W-1:0] d;
        d = '0;
        for (int i = 0; i < N; i++) begin
            d[i*W +: W] = base + W'(i);
        end
        return d;
    endfunction

    task automatic model_grant(input logic r, input logic [N-1:0] v, input logic [SW-1:0] s,
                               input logic md, input logic ordy,
                               output logic [N-1:0] rdy, output int g);
        logic [2*N-1:0] dbl;
        rdy = '0;
        g   = -1;
        if (!r && (!m_valid || ordy)) begin
            if (RR && md) begin
                dbl = {v, v} >> m_ptr;
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && dbl[k]) g = (m_ptr + k) % N;
                end
            end else if (int'(s) < N) begin
                g = int'(s);
            end
            if (g >= 0) rdy[g] = 1'b1;
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] d,
                        input logic [SW-1:0] s, input logic md, input logic ordy);
        logic [N-1:0]    exp_rdy;
        int              g;
        logic [SW+W-1:0] e;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        in_data   = d;
        sel       = s;
        mode      = md;
        out_ready = ordy;
        #1;
        model_grant(r, v, s, md, ordy, exp_rdy, g);
        check("in_ready", in_ready, exp_rdy);
        if (r) begin
            sb.delete();
            m_valid     = 1'b0;
            m_ptr       = 0;
            m_last_data = '0;
            m_last_ch   = '0;
        end else begin
            if (m_valid && ordy && sb.size() > 0) begin
                e           = sb.pop_front();
                m_last_ch   = e[SW+W-1:W];
                m_last_data = e[W-1:0];
                m_valid     = 1'b0;
            end
            if (|(v & exp_rdy)) begin
                sb.push_back({SW'(g), d[g*W +: W]});
                m_valid = 1'b1;
                if (RR && md) m_ptr = (g + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_valid);
        if (m_valid && sb.size() > 0) begin
            e = sb[0];
            check("out_ch", out_ch, e[SW+W-1:W]);
            check("out_data", out_data, e[W-1:0]);
        end else begin
            check("out_ch_hold", out_ch, m_last_ch);
            check("out_data_hold", out_data, m_last_data);
        end
`ifdef MUX_RR_EN
        check("ptr", dut.ptr_q, m_ptr);
`endif
    endtask

    initial begin
        step(1'b1, 8'hFF, ramp(4'h1), 3'd0, 1'b0, 1'b1);
        step(1'b1, 8'hFF, ramp(4'h1), 3'd0, 1'b0, 1'b1);

        // fixed select, channel 5 carries 4'hA
        step(1'b0, 8'h20, ramp(4'h5), 3'd5, 1'b0, 1'b1);
        step(1'b0, 8'h00, ramp(4'h0), 3'd5, 1'b0, 1'b1);

        // word 7 on ch2, then a three-cycle stall, then accept next word
        step(1'b0, 8'h04, ramp(4'h5), 3'd2, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h04, ramp(4'h9), 3'd2, 1'b0, 1'b0);
        step(1'b0, 8'h04, ramp(4'h9), 3'd2, 1'b0, 1'b1);
        step(1'b0, 8'h00, ramp(4'h0), 3'd2, 1'b0, 1'b1);

`ifdef MUX_RR_EN
        for (int i = 0; i < 10; i++) step(1'b0, 8'hFF, ramp(4'h1), 3'd0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++)  step(1'b0, 8'hFF, ramp(4'h3), 3'd0, 1'b1, 1'b1);
        step(1'b0, 8'h09, ramp(4'h3), 3'd0, 1'b1, 1'b1);
        step(1'b0, 8'h09, ramp(4'h6), 3'd0, 1'b1, 1'b1);
        step(1'b0, 8'h40, ramp(4'h2), 3'd6, 1'b0, 1'b1);
        step(1'b0, 8'h00, ramp(4'h0), 3'd6, 1'b1, 1'b1);
`else
        for (int i = 0; i < 4; i++) step(1'b0, 8'hFF, ramp(4'h1), 3'd2, 1'b1, 1'b1);
        step(1'b0, 8'hFF, ramp(4'h2), 3'd2, 1'b1, 1'b0);
        step(1'b0, 8'hFF, ramp(4'h3), 3'd2, 1'b1, 1'b1);
`endif

        // reset while stalled discards the held word
        step(1'b0, 8'hFF, ramp(4'h2), 3'd1, 1'b1, 1'b1);
        step(1'b0, 8'hFF, ramp(4'h2), 3'd1, 1'b1, 1'b0);
        step(1'b1, 8'hFF, ramp(4'h2), 3'd1, 1'b1, 1'b0);
        step(1'b0, 8'hFF, ramp(4'h4), 3'd1, 1'b1, 1'b1);

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 29) == 0), N'($urandom), (N*W)'($urandom),
                 SW'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
        end

        step(1'b0, 8'h00, ramp(4'h0), 3'd0, 1'b0, 1'b1);
        step(1'b0, 8'h00, ramp(4'h0), 3'd0, 1'b0, 1'b1);
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
